// File: rtl/slice_pulse_gen_pkg.sv
// Shared types and widths for the slice pulse generator and its slice counter.
package slice_pulse_gen_pkg;

  localparam int unsigned COORD_W_DEF = 10;
  localparam int unsigned SLICE_CNT_W = 5;
  localparam int unsigned IN_CNT_W    = 4;
  localparam int unsigned CD_CNT_W    = 8;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ARM      = 3'd1,
    OUTSIDE  = 3'd2,
    INSIDE   = 3'd3,
    COOLDOWN = 3'd4,
    DONE     = 3'd5
  } state_t;

endpackage

// File: rtl/slice_pulse_gen_if.sv
// Blade sample / fruit box inputs and slice outputs of the slice pulse generator.
interface slice_pulse_gen_if
  import slice_pulse_gen_pkg::*;
#(
  parameter int unsigned COORD_W = COORD_W_DEF
);

  logic               sample_valid_i;
  logic [COORD_W-1:0] blade_x_i;
  logic [COORD_W-1:0] blade_y_i;
  logic               fruit_active_i;
  logic [COORD_W-1:0] box_x0_i;
  logic [COORD_W-1:0] box_x1_i;
  logic [COORD_W-1:0] box_y0_i;
  logic [COORD_W-1:0] box_y1_i;
  logic               slice_o;
  logic               done_o;
  logic               inside_o;

  // Producer of samples / consumer of slice pulses (game logic, testbench)
  modport master (
    output sample_valid_i, blade_x_i, blade_y_i, fruit_active_i,
    output box_x0_i, box_x1_i, box_y0_i, box_y1_i,
    input  slice_o, done_o, inside_o
  );

  // The pulse generator itself
  modport slave (
    input  sample_valid_i, blade_x_i, blade_y_i, fruit_active_i,
    input  box_x0_i, box_x1_i, box_y0_i, box_y1_i,
    output slice_o, done_o, inside_o
  );

endinterface

// File: rtl/slice_pulse_gen_box_hit_cmp.sv
// Unsigned point-in-box test with inclusive edges.
module box_hit_cmp #(
  parameter int unsigned COORD_W = 10
) (
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] y,
  input  logic [COORD_W-1:0] x0,
  input  logic [COORD_W-1:0] x1,
  input  logic [COORD_W-1:0] y0,
  input  logic [COORD_W-1:0] y1,
  output logic               hit
);

  // A degenerate box (x0>x1 or y0>y1) can never satisfy both bounds, so it never hits.
  always_comb begin
    hit = (x >= x0) && (x <= x1) && (y >= y0) && (y <= y1);
  end

endmodule

// File: rtl/slice_pulse_gen.sv
// Emits one single-cycle slice pulse per blade pass (enter then exit) through the
// active fruit's box, with debounce, post-slice cooldown and a per-fruit cap.
module slice_pulse_gen
  import slice_pulse_gen_pkg::*;
#(
  parameter int unsigned COORD_W      = COORD_W_DEF,
  parameter int unsigned MIN_IN       = 2,
  parameter int unsigned COOLDOWN_CYC = 4,
  parameter int unsigned MAX_SLICES   = 31
) (
  input logic            clk,
  input logic            rst_n,
  slice_pulse_gen_if.slave bus
);

  localparam logic [IN_CNT_W-1:0]    MIN_IN_L  = IN_CNT_W'(MIN_IN);
  localparam logic [IN_CNT_W-1:0]    IN_SAT    = '1;
  localparam logic [SLICE_CNT_W-1:0] MAX_L     = SLICE_CNT_W'(MAX_SLICES);
  localparam logic [CD_CNT_W-1:0]    CD_LAST   = CD_CNT_W'(COOLDOWN_CYC - 1);

  state_t                 state_q, state_d;
  logic [SLICE_CNT_W-1:0] slice_cnt_q, slice_cnt_d, slice_inc;
  logic [IN_CNT_W-1:0]    in_cnt_q, in_cnt_d;
  logic [CD_CNT_W-1:0]    cd_cnt_q, cd_cnt_d;
  logic                   slice_q, slice_d;
  logic                   inside_q;
  logic                   hit;

  box_hit_cmp #(.COORD_W(COORD_W)) u_hit (
    .x   (bus.blade_x_i),
    .y   (bus.blade_y_i),
    .x0  (bus.box_x0_i),
    .x1  (bus.box_x1_i),
    .y0  (bus.box_y0_i),
    .y1  (bus.box_y1_i),
    .hit (hit)
  );

  assign slice_inc = slice_cnt_q + SLICE_CNT_W'(1);

  // Next-state, counter and pulse decode; fruit loss overrides everything
  always_comb begin
    state_d     = state_q;
    slice_cnt_d = slice_cnt_q;
    in_cnt_d    = in_cnt_q;
    cd_cnt_d    = cd_cnt_q;
    slice_d     = 1'b0;
    if (!bus.fruit_active_i) begin
      state_d     = IDLE;
      slice_cnt_d = '0;
      in_cnt_d    = '0;
      cd_cnt_d    = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d     = ARM;
          slice_cnt_d = '0;
        end
        ARM: begin
          if (bus.sample_valid_i && !hit) state_d = OUTSIDE;
        end
        OUTSIDE: begin
          if (bus.sample_valid_i && hit) begin
            state_d  = INSIDE;
            in_cnt_d = IN_CNT_W'(1);
          end
        end
        INSIDE: begin
          if (bus.sample_valid_i) begin
            if (hit) begin
              if (in_cnt_q != IN_SAT) in_cnt_d = in_cnt_q + IN_CNT_W'(1);
            end else if (in_cnt_q >= MIN_IN_L) begin
              slice_d     = 1'b1;
              slice_cnt_d = slice_inc;
              if (slice_inc == MAX_L) begin
                state_d = DONE;
              end else if (COOLDOWN_CYC == 0) begin
                state_d = OUTSIDE;
              end else begin
                state_d  = COOLDOWN;
                cd_cnt_d = '0;
              end
            end else begin
              state_d = OUTSIDE;
            end
          end
        end
        COOLDOWN: begin
          cd_cnt_d = cd_cnt_q + CD_CNT_W'(1);
          if (cd_cnt_q == CD_LAST) state_d = OUTSIDE;
        end
        DONE: begin
          state_d = DONE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State, counters and registered slice pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      slice_cnt_q <= '0;
      in_cnt_q    <= '0;
      cd_cnt_q    <= '0;
      slice_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      slice_cnt_q <= slice_cnt_d;
      in_cnt_q    <= in_cnt_d;
      cd_cnt_q    <= cd_cnt_d;
      slice_q     <= slice_d;
    end
  end

  // Inside flag follows every valid sample, whatever the FSM is doing
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inside_q <= 1'b0;
    end else if (bus.sample_valid_i) begin
      inside_q <= hit;
    end
  end

  assign bus.slice_o  = slice_q;
  assign bus.done_o   = (state_q == DONE);
  assign bus.inside_o = inside_q;

endmodule

// File: tb/tb_slice_pulse_gen.sv
// Self-checking bench for slice_pulse_gen: directed scenarios plus randomized
// blade walks, all compared against a pass-level behavioural model.
module tb_slice_pulse_gen;

  localparam int MIN_IN   = 2;
  localparam int COOLDOWN = 4;
  localparam int MAX_SL   = 3;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  slice_pulse_gen_if #(.COORD_W(10)) bus ();

  slice_pulse_gen #(
    .COORD_W      (10),
    .MIN_IN       (MIN_IN),
    .COOLDOWN_CYC (COOLDOWN),
    .MAX_SLICES   (MAX_SL)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model of a fruit's scoring life, tracked as passes rather than FSM states
  int b_x0, b_x1, b_y0, b_y1;
  bit m_active;   // fruit seen for at least one cycle
  bit m_armed;    // blade has been seen outside since the fruit appeared
  int m_run;      // consecutive inside samples in the current pass
  int m_cd_left;  // cycles of cooldown still to elapse
  int m_slices;
  bit m_done;
  bit m_inside;
  bit m_pulse;
  int pulses;

  function automatic bit in_box(input int x, input int y);
    return (x >= b_x0) && (x <= b_x1) && (y >= b_y0) && (y <= b_y1);
  endfunction

  task automatic model_reset();
    m_active = 0; m_armed = 0; m_run = 0; m_cd_left = 0;
    m_slices = 0; m_done = 0; m_inside = 0; m_pulse = 0;
  endtask

  task automatic model_step(input bit v, input int x, input int y, input bit fa);
    bit hit;
    hit = in_box(x, y);
    m_pulse = 0;
    if (v) m_inside = hit;
    if (!fa) begin
      m_active = 0; m_armed = 0; m_run = 0; m_cd_left = 0; m_slices = 0; m_done = 0;
    end else if (!m_active) begin
      m_active = 1; m_armed = 0; m_slices = 0;
    end else if (m_done) begin
      m_done = 1;
    end else if (m_cd_left > 0) begin
      m_cd_left--;
    end else if (v) begin
      if (!m_armed) begin
        if (!hit) begin m_armed = 1; m_run = 0; end
      end else if (hit) begin
        m_run = (m_run < 15) ? m_run + 1 : 15;
      end else begin
        if (m_run >= MIN_IN) begin
          m_pulse = 1;
          m_slices++;
          if (m_slices == MAX_SL) m_done = 1;
          else m_cd_left = COOLDOWN;
        end
        m_run = 0;
      end
    end
  endtask

  task automatic set_box(input int x0, input int x1, input int y0, input int y1);
    b_x0 = x0; b_x1 = x1; b_y0 = y0; b_y1 = y1;
    bus.box_x0_i = 10'(x0); bus.box_x1_i = 10'(x1);
    bus.box_y0_i = 10'(y0); bus.box_y1_i = 10'(y1);
  endtask

  // Apply one cycle of inputs, advance the model, then sit 1ns past the edge
  task automatic drive(input bit v, input int x, input int y, input bit fa);
    bus.sample_valid_i = v;
    bus.blade_x_i      = 10'(x);
    bus.blade_y_i      = 10'(y);
    bus.fruit_active_i = fa;
    model_step(v, x, y, fa);
    @(posedge clk);
    #1;
    if (bus.slice_o === 1'b1) pulses++;
  endtask

  task automatic new_fruit();
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 1);
  endtask

  task automatic test_reset();
    n_tests++;
    if ({bus.slice_o, bus.done_o, bus.inside_o} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset: got %b want 000", {bus.slice_o, bus.done_o, bus.inside_o});
    end
  endtask

  task automatic test_basic();
    int xs[4] = '{50, 120, 150, 250};
    bit exp_in[4] = '{0, 1, 1, 0};
    new_fruit();
    for (int i = 0; i < 4; i++) begin
      drive(1, xs[i], 100, 1);
      n_tests++;
      if (bus.slice_o !== (i == 3) || bus.inside_o !== exp_in[i]) begin
        n_fail++;
        $display("FAIL basic s%0d: got slice=%b inside=%b want slice=%b inside=%b",
                 i, bus.slice_o, bus.inside_o, (i == 3), exp_in[i]);
      end
    end
    drive(0, 250, 100, 1);
    n_tests++;
    if (bus.slice_o !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_one_cycle: got slice=%b want 0", bus.slice_o);
    end
  endtask

  task automatic test_graze();
    int xs[7] = '{50, 120, 250, 50, 120, 150, 250};
    new_fruit();
    pulses = 0;
    for (int i = 0; i < 7; i++) begin
      drive(1, xs[i], 100, 1);
      n_tests++;
      if ({bus.slice_o, bus.done_o, bus.inside_o} !== {m_pulse, m_done, m_inside}) begin
        n_fail++;
        $display("FAIL graze s%0d: got %b want %b", i,
                 {bus.slice_o, bus.done_o, bus.inside_o}, {m_pulse, m_done, m_inside});
      end
    end
    n_tests++;
    if (pulses !== 1) begin
      n_fail++;
      $display("FAIL graze_count: got %0d pulses want 1", pulses);
    end
  endtask

  task automatic test_cooldown();
    int xs[12] = '{50, 120, 150, 250, 120, 250, 150, 250, 50, 120, 150, 250};
    new_fruit();
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      drive(1, xs[i], 100, 1);
      n_tests++;
      if ({bus.slice_o, bus.done_o, bus.inside_o} !== {m_pulse, m_done, m_inside}) begin
        n_fail++;
        $display("FAIL cooldown s%0d: got %b want %b", i,
                 {bus.slice_o, bus.done_o, bus.inside_o}, {m_pulse, m_done, m_inside});
      end
    end
    drive(0, 0, 0, 1);
    n_tests++;
    if (pulses !== 2) begin
      n_fail++;
      $display("FAIL cooldown_count: got %0d pulses want 2", pulses);
    end
  endtask

  task automatic test_cap();
    int xs[4] = '{50, 120, 150, 250};
    new_fruit();
    pulses = 0;
    for (int p = 0; p < 4; p++) begin
      for (int i = 0; i < 4 + COOLDOWN; i++) begin
        if (i < 4) drive(1, xs[i], 100, 1);
        else drive(0, 0, 0, 1);
        n_tests++;
        if ({bus.slice_o, bus.done_o, bus.inside_o} !== {m_pulse, m_done, m_inside}) begin
          n_fail++;
          $display("FAIL cap p%0d s%0d: got %b want %b", p, i,
                   {bus.slice_o, bus.done_o, bus.inside_o}, {m_pulse, m_done, m_inside});
        end
      end
    end
    n_tests++;
    if (pulses !== 3 || bus.done_o !== 1'b1) begin
      n_fail++;
      $display("FAIL cap_limit: got %0d pulses done=%b want 3 pulses done=1", pulses, bus.done_o);
    end
    drive(0, 0, 0, 0);
    n_tests++;
    if (bus.done_o !== 1'b0) begin
      n_fail++;
      $display("FAIL cap_clear: got done=%b want 0", bus.done_o);
    end
    drive(0, 0, 0, 1);
    pulses = 0;
    for (int i = 0; i < 5; i++) drive(1, (i < 4) ? xs[i] : 50, 100, 1);
    n_tests++;
    if (pulses !== 1) begin
      n_fail++;
      $display("FAIL cap_next_fruit: got %0d pulses want 1", pulses);
    end
  endtask

  task automatic test_spawn();
    int xs[6] = '{150, 250, 120, 150, 250, 50};
    drive(0, 150, 100, 0);
    drive(1, 150, 100, 1);
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      drive(1, xs[i], 100, 1);
      n_tests++;
      if ({bus.slice_o, bus.done_o, bus.inside_o} !== {m_pulse, m_done, m_inside}) begin
        n_fail++;
        $display("FAIL spawn s%0d: got %b want %b", i,
                 {bus.slice_o, bus.done_o, bus.inside_o}, {m_pulse, m_done, m_inside});
      end
      if (i == 1) begin
        n_tests++;
        if (pulses !== 0) begin
          n_fail++;
          $display("FAIL spawn_no_score: got %0d pulses want 0", pulses);
        end
      end
    end
    n_tests++;
    if (pulses !== 1) begin
      n_fail++;
      $display("FAIL spawn_later_pass: got %0d pulses want 1", pulses);
    end
  endtask

  task automatic test_abort();
    new_fruit();
    drive(1, 50, 100, 1);
    drive(1, 120, 100, 1);
    drive(1, 150, 100, 1);
    drive(1, 250, 100, 0);
    n_tests++;
    if (bus.slice_o !== 1'b0 || bus.done_o !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_exit: got slice=%b done=%b want 0 0", bus.slice_o, bus.done_o);
    end
    // Back in IDLE: the next cycle only arms, so an immediate exit cannot score
    drive(1, 250, 100, 1);
    drive(1, 120, 100, 1);
    n_tests++;
    if ({bus.slice_o, bus.inside_o} !== 2'b01) begin
      n_fail++;
      $display("FAIL abort_rearm: got %b want 01", {bus.slice_o, bus.inside_o});
    end
    drive(1, 150, 100, 1);
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if ({bus.slice_o, bus.done_o, bus.inside_o} !== 3'b000) begin
      n_fail++;
      $display("FAIL async_reset: got %b want 000", {bus.slice_o, bus.done_o, bus.inside_o});
    end
    model_reset();
    #2 rst_n = 1'b1;
    drive(1, 250, 100, 1);
    n_tests++;
    if (bus.slice_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_lost_pulse: got slice=%b want 0", bus.slice_o);
    end
  endtask

  task automatic test_random();
    int x, y, x0, y0;
    bit v, fa;
    x = 150; y = 100;
    for (int c = 0; c < 3000; c++) begin
      fa = ($urandom_range(0, 59) != 0);
      if (!fa) begin
        x0 = $urandom_range(0, 400);
        y0 = $urandom_range(0, 400);
        if ($urandom_range(0, 7) == 0)
          set_box(x0, x0 - $urandom_range(1, 50), y0, y0 + $urandom_range(0, 120));
        else
          set_box(x0, x0 + $urandom_range(0, 150), y0, y0 + $urandom_range(0, 150));
      end
      x = x + $urandom_range(0, 80) - 40;
      y = y + $urandom_range(0, 80) - 40;
      if (x < 0) x = 0;
      if (x > 1023) x = 1023;
      if (y < 0) y = 0;
      if (y > 1023) y = 1023;
      if ($urandom_range(0, 15) == 0) begin
        x = (b_x0 + b_x1) / 2;
        y = (b_y0 + b_y1) / 2;
        if (x > 1023) x = 1023;
        if (y > 1023) y = 1023;
      end
      v = ($urandom_range(0, 3) != 0);
      drive(v, x, y, fa);
      n_tests++;
      if ({bus.slice_o, bus.done_o, bus.inside_o} !== {m_pulse, m_done, m_inside}) begin
        n_fail++;
        $display("FAIL random c%0d: got %b want %b", c,
                 {bus.slice_o, bus.done_o, bus.inside_o}, {m_pulse, m_done, m_inside});
      end
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    pulses  = 0;
    rst_n   = 1'b0;
    bus.sample_valid_i = 1'b0;
    bus.blade_x_i      = '0;
    bus.blade_y_i      = '0;
    bus.fruit_active_i = 1'b0;
    set_box(100, 200, 50, 150);
    model_reset();
    #3;
    test_reset();
    #9 rst_n = 1'b1;
    test_basic();
    test_graze();
    test_cooldown();
    test_cap();
    test_spawn();
    test_abort();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/slice_pulse_gen.md
Name: slice_pulse_gen

Overview:
Producer side of the slice-count interface. It watches blade position samples against the active fruit's bounding box and emits one single-cycle slice pulse per valid pass, where a valid pass means the blade enters the box and then exits it. The slice pulse drives the downstream slice counter's increment input directly. The block also applies debounce, cooldown and a per-fruit cap, so the 5-bit piece count downstream never overflows.

Parameters:
COORD_W, 10, width of all x/y coordinates (unsigned)
MIN_IN, 2, minimum consecutive valid inside-samples for an exit to count as a slice (1..15)
COOLDOWN_CYC, 4, clock cycles after a slice during which samples are ignored (0..255)
MAX_SLICES, 31, slices allowed per fruit (1..31)

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
sample_valid_i  input  1  blade_x_i/blade_y_i hold a new sample this cycle
blade_x_i  input  COORD_W  blade x position
blade_y_i  input  COORD_W  blade y position
fruit_active_i  input  1  a fruit is on screen; box inputs are stable while high
box_x0_i  input  COORD_W  box left edge, inclusive
box_x1_i  input  COORD_W  box right edge, inclusive
box_y0_i  input  COORD_W  box top edge, inclusive
box_y1_i  input  COORD_W  box bottom edge, inclusive
slice_o  output  1  one-cycle slice pulse; connects to the counter's increment input
done_o  output  1  MAX_SLICES reached for the current fruit
inside_o  output  1  registered: last valid sample was inside the box

Behaviour:
- Interface: reset rst_n, asynchronous, active-low; clock clk.
- Reset: slice_o=0, done_o=0, inside_o=0, state=IDLE, all counters 0.
- Hit test (combinational): inside = (x0<=x<=x1) && (y0<=y<=y1), unsigned.
  - Degenerate box (x0>x1 or y0>y1) never hits.
  - The hit test is evaluated only when sample_valid_i=1. Non-valid cycles change no state and no counter, except the cooldown timer.
- inside_o updates on every valid sample.
- FSM states: IDLE, ARM, OUTSIDE, INSIDE, COOLDOWN, DONE.
  - IDLE: when fruit_active_i=1, go to ARM and clear slice_cnt.
  - ARM: on a valid outside sample, go to OUTSIDE. Inside samples keep ARM, so a fruit spawning under the blade never scores.
  - OUTSIDE: on a valid inside sample, go to INSIDE with in_cnt=1.
  - INSIDE, valid inside sample: in_cnt increments, saturating at 15.
  - INSIDE, valid outside sample with in_cnt>=MIN_IN: slice. Register slice_o=1 and increment slice_cnt.
    - If the new slice_cnt==MAX_SLICES, go to DONE.
    - Else if COOLDOWN_CYC=0, go to OUTSIDE.
    - Else go to COOLDOWN with cd_cnt=0.
  - INSIDE, valid outside sample with in_cnt<MIN_IN: graze. Go to OUTSIDE with no pulse.
  - COOLDOWN: cd_cnt increments every clk. When cd_cnt reaches COOLDOWN_CYC-1, go to OUTSIDE. Samples are ignored, but inside_o still tracks them.
  - DONE: done_o=1. Stay until fruit_active_i=0.
- fruit_active_i=0 in any state: next state is IDLE, and slice_cnt, in_cnt, cd_cnt and done_o are cleared.
  - This has priority over a same-cycle exit sample, so no pulse is produced.
- Latency: an exit sample presented in cycle k gives slice_o=1 in cycle k+1 only. Slice pulses are never back-to-back.
- Reset asserted mid-operation clears everything immediately (asynchronous). Any pending pulse is lost.
- Counter widths: slice_cnt 5 bits, in_cnt 4 bits saturating, cd_cnt 8 bits.

Decomposition:
- Shared package: FSM state enum (3-bit encoding), COORD_W default, SLICE_CNT_W=5 (shared with the slice counter).
- One combinational sub-module, box_hit_cmp: point-in-box compare, parameterised by COORD_W. All sequencing stays in the top module.

Test Plan:
Common setup: MIN_IN=2, COOLDOWN_CYC=4, MAX_SLICES=3, box x 100..200, y 50..150, fruit_active_i=1.
- Basic slice: valid samples (50,100),(120,100),(150,100),(250,100) on consecutive cycles -> slice_o=1 exactly one cycle after the (250,100) sample, 0 otherwise; inside_o 0,1,1,0.
- Graze: (50,100),(120,100),(250,100) -> no pulse. A following full pass gives exactly one pulse.
- Cooldown: after a slice, inside/outside samples in the next 4 cycles produce no pulse. A re-entry pass starting after cooldown produces a second pulse.
- Cap: three full passes -> 3 pulses, then done_o=1. A fourth pass gives no pulse. fruit_active_i=0 for one cycle -> done_o=0 and the next fruit scores again.
- Spawn under blade: fruit_active_i rises while the blade is at (150,100), then (250,100) -> no pulse. A later full pass gives 1 pulse.
- Abort: fruit_active_i falls in the same cycle as the exit sample -> no pulse, state IDLE. Asserting rst_n=0 asynchronously mid-INSIDE clears inside_o before the next clk edge.
